// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: ID/EX hazard sources in, stage enables/flushes and stats out.
// Latency: none; this is wiring only.
// Backpressure: none of its own; imem_rdy/dmem_rdy carry memory readiness to the controller.
interface hazard_ctrl_if;
  logic [3:0]  id_rs;
  logic [3:0]  id_rt;
  logic        id_rs_used;
  logic        id_rt_used;
  logic        ex_mem_read;
  logic [3:0]  ex_rd;
  logic        br_taken;
  logic        id_hlt;
  logic        imem_rdy;
  logic        dmem_req;
  logic        dmem_rdy;
  logic        pc_we;
  logic        if_id_we;
  logic        id_ex_we;
  logic        ex_mem_we;
  logic        mem_wb_we;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  // Pipeline side: drives hazard sources, consumes enables
  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used, ex_mem_read, ex_rd,
           br_taken, id_hlt, imem_rdy, dmem_req, dmem_rdy,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, halted, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used, ex_mem_read, ex_rd,
           br_taken, id_hlt, imem_rdy, dmem_req, dmem_rdy,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: freeze, load-use stall, branch/fetch flush, halt drain.
// Latency: enables/flushes combinational same cycle; state, drain count and stats update on clk.
// Backpressure: dmem busy freezes the whole pipe; imem not ready holds PC and bubbles IF/ID.
module hazard_ctrl (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  state_t      state_q, state_d, cur_state;
  logic [1:0]  drn_q, drn_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        dm_busy, lu, im_busy;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_flush, id_ex_flush, halted;

  // Hazard detection; a load to r0 never creates a dependency
  always_comb begin
    dm_busy = hz.dmem_req & ~hz.dmem_rdy;
    im_busy = ~hz.imem_rdy;
    lu      = hz.ex_mem_read & (hz.ex_rd != 4'd0) &
              ((hz.id_rs_used & (hz.id_rs == hz.ex_rd)) |
               (hz.id_rt_used & (hz.id_rt == hz.ex_rd)));
  end

  // Next state and stage controls; reset makes outputs behave as RUN immediately
  always_comb begin
    cur_state   = rst ? RUN : state_q;
    state_d     = state_q;
    drn_d       = drn_q;
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    id_ex_we    = 1'b0;
    ex_mem_we   = 1'b0;
    mem_wb_we   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;
    case (cur_state)
      RUN: begin
        if (dm_busy) begin
          // full freeze: everything holds
        end else if (lu) begin
          id_ex_we    = 1'b1;
          id_ex_flush = 1'b1;
          ex_mem_we   = 1'b1;
          mem_wb_we   = 1'b1;
        end else if (hz.br_taken || hz.id_hlt) begin
          pc_we       = 1'b1;
          if_id_we    = 1'b1;
          id_ex_we    = 1'b1;
          ex_mem_we   = 1'b1;
          mem_wb_we   = 1'b1;
          if_id_flush = 1'b1;
          if (!hz.br_taken) begin
            state_d = DRAIN;
            drn_d   = 2'd0;
          end
        end else if (im_busy) begin
          if_id_we    = 1'b1;
          id_ex_we    = 1'b1;
          ex_mem_we   = 1'b1;
          mem_wb_we   = 1'b1;
          if_id_flush = 1'b1;
        end else begin
          pc_we     = 1'b1;
          if_id_we  = 1'b1;
          id_ex_we  = 1'b1;
          ex_mem_we = 1'b1;
          mem_wb_we = 1'b1;
        end
      end
      DRAIN: begin
        if (!dm_busy) begin
          if_id_we    = 1'b1;
          id_ex_we    = 1'b1;
          ex_mem_we   = 1'b1;
          mem_wb_we   = 1'b1;
          if_id_flush = 1'b1;
          drn_d       = 2'(drn_q + 2'd1);
          if (drn_q == 2'd3) state_d = HALTED;
        end
      end
      HALTED: halted = 1'b1;
      default: state_d = RUN;
    endcase
  end

  // Saturating statistics; stalls are not counted once halted
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_we && cur_state != HALTED && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    if ((if_id_flush || id_ex_flush) && flush_cnt_q != 16'hFFFF)
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      drn_q       <= 2'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      drn_q       <= drn_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.pc_we       = pc_we;
  assign hz.if_id_we    = if_id_we;
  assign hz.id_ex_we    = id_ex_we;
  assign hz.ex_mem_we   = ex_mem_we;
  assign hz.mem_wb_we   = mem_wb_we;
  assign hz.if_id_flush = if_id_flush;
  assign hz.id_ex_flush = id_ex_flush;
  assign hz.halted      = halted;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule
